ttt_move_ctrl: RTL and testbench

- Synchronous game controller for the tic-tac-toe board.
- Sits between the keypad scanner, which supplies decoded key pulses, and the 7-segment and dot-matrix display stages, which consume board, turn, result and board-shift state.
- Validates moves, writes the 18-bit board, alternates turns, detects win or draw, and handles restart.
- All state is held in clocked registers; there is no event-triggered logic.

---
 rtl/ttt_move_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ttt_move_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ttt_move_ctrl.sv
// Tic-tac-toe move controller: takes decoded key pulses, validates and
// places stones on the 18-bit board, alternates turns, detects win/draw
// and handles restart. Every output is a register.
//
// Handshake: key_valid is a one-cycle strobe that qualifies key_code in
// the same cycle; there is no ready/back-pressure, so a key that arrives
// while the controller cannot use it (CHECK, IDLE, DONE with a non-restart
// key) is simply dropped.
module ttt_move_ctrl #(
  parameter logic       FIRST_O     = 1'b0,
  parameter logic [3:0] RESTART_KEY = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play_en,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [17:0] board,
  output logic        turn_o,
  output logic [1:0]  result,
  output logic [7:0]  win_line,
  output logic        is_right,
  output logic        game_active,
  output logic        move_err,
  output logic [3:0]  move_cnt,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  state_t state, state_nx;

  logic [17:0] board_nx;
  logic        turn_nx;
  logic [1:0]  result_nx;
  logic [7:0]  win_line_nx;
  logic        is_right_nx;
  logic        game_active_nx;
  logic        move_err_nx;
  logic [3:0]  move_cnt_nx;

  logic [8:0]  x_bits, o_bits;
  logic        cell_key;
  logic [3:0]  cell_idx;
  logic        occupied;
  logic        restart_key;
  logic [7:0]  mover_mask;

  // Completed-line mask for one player's 9 cells (index 0 = cell 1).
  function automatic logic [7:0] line_mask(input logic [8:0] p);
    line_mask[0] = p[0] & p[1] & p[2];
    line_mask[1] = p[3] & p[4] & p[5];
    line_mask[2] = p[6] & p[7] & p[8];
    line_mask[3] = p[0] & p[3] & p[6];
    line_mask[4] = p[1] & p[4] & p[7];
    line_mask[5] = p[2] & p[5] & p[8];
    line_mask[6] = p[0] & p[4] & p[8];
    line_mask[7] = p[2] & p[4] & p[6];
  endfunction

  // Split the board into per-player cell vectors and decode the key.
  always_comb begin
    x_bits = '0;
    o_bits = '0;
    for (int i = 0; i < 9; i++) begin
      x_bits[i] = board[16-2*i];
      o_bits[i] = board[17-2*i];
    end
    cell_key    = key_valid && (key_code >= 4'd1) && (key_code <= 4'd9);
    cell_idx    = key_code - 4'd1;
    occupied    = cell_key && (x_bits[cell_idx] || o_bits[cell_idx]);
    restart_key = key_valid && (key_code == RESTART_KEY);
    // turn_o has not toggled yet in CHECK, so it names the player who just moved
    mover_mask  = turn_o ? line_mask(o_bits) : line_mask(x_bits);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; leaving game mode wins over any concurrent key.
  always_comb begin
    state_nx = state;
    if (!play_en) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nx = S_PLAY;
        S_PLAY:  if (cell_key && !occupied) state_nx = S_CHECK;
        S_CHECK: begin
          if (mover_mask != 8'd0)       state_nx = S_DONE;
          else if (move_cnt == 4'd9)    state_nx = S_DONE;
          else                          state_nx = S_PLAY;
        end
        S_DONE:  if (restart_key) state_nx = S_PLAY;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Next values for the registered outputs.
  always_comb begin
    board_nx       = board;
    turn_nx        = turn_o;
    result_nx      = result;
    win_line_nx    = win_line;
    move_cnt_nx    = move_cnt;
    move_err_nx    = 1'b0;
    is_right_nx    = is_right;
    game_active_nx = (state_nx == S_PLAY) || (state_nx == S_CHECK);

    // Board-shift keys act in every state, independent of play_en.
    if (key_valid && key_code == KEY_STAR) is_right_nx = 1'b0;
    if (key_valid && key_code == KEY_HASH) is_right_nx = 1'b1;

    if (!play_en || state == S_IDLE || (state == S_DONE && restart_key)) begin
      board_nx    = '0;
      move_cnt_nx = '0;
      result_nx   = 2'd0;
      win_line_nx = '0;
      turn_nx     = FIRST_O;
    end else if (state == S_PLAY && cell_key) begin
      if (occupied) begin
        move_err_nx = 1'b1;
      end else begin
        for (int i = 0; i < 9; i++) begin
          if (cell_idx == i[3:0]) begin
            if (turn_o) board_nx[17-2*i] = 1'b1;
            else        board_nx[16-2*i] = 1'b1;
          end
        end
        move_cnt_nx = (move_cnt == 4'd9) ? 4'd9 : move_cnt + 4'd1;
      end
    end else if (state == S_CHECK) begin
      win_line_nx = mover_mask;
      if (mover_mask != 8'd0)    result_nx = turn_o ? 2'd2 : 2'd1;
      else if (move_cnt == 4'd9) result_nx = 2'd3;
      else                       turn_nx   = ~turn_o;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      board       <= '0;
      turn_o      <= FIRST_O;
      result      <= 2'd0;
      win_line    <= '0;
      is_right    <= 1'b0;
      game_active <= 1'b0;
      move_err    <= 1'b0;
      move_cnt    <= '0;
    end else begin
      board       <= board_nx;
      turn_o      <= turn_nx;
      result      <= result_nx;
      win_line    <= win_line_nx;
      is_right    <= is_right_nx;
      game_active <= game_active_nx;
      move_err    <= move_err_nx;
      move_cnt    <= move_cnt_nx;
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Directed bench for ttt_move_ctrl: scripted games with hand-computed
// board/result values, checked with immediate assertions.
module tb_ttt_move_ctrl;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_PLAY = 2'd1, ST_CHECK = 2'd2, ST_DONE = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        play_en;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [17:0] board;
  logic        turn_o;
  logic [1:0]  result;
  logic [7:0]  win_line;
  logic        is_right;
  logic        game_active;
  logic        move_err;
  logic [3:0]  move_cnt;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  ttt_move_ctrl #(.FIRST_O(1'b0), .RESTART_KEY(4'd0)) dut (
    .clk(clk), .rst(rst), .play_en(play_en), .key_valid(key_valid),
    .key_code(key_code), .board(board), .turn_o(turn_o), .result(result),
    .win_line(win_line), .is_right(is_right), .game_active(game_active),
    .move_err(move_err), .move_cnt(move_cnt), .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #20 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One-cycle key strobe; returns at the negedge right after it was sampled.
  task automatic key_pulse(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  // Key strobe plus one cycle so a move has been fully checked on return.
  task automatic press(input logic [3:0] code);
    key_pulse(code);
    step();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_board"},  32'(board), 32'd0);
    chk({tag, "_turn"},   32'(turn_o), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_win"},    32'(win_line), 32'd0);
    chk({tag, "_right"},  32'(is_right), 32'd0);
    chk({tag, "_active"}, 32'(game_active), 32'd0);
    chk({tag, "_err"},    32'(move_err), 32'd0);
    chk({tag, "_cnt"},    32'(move_cnt), 32'd0);
    chk({tag, "_state"},  32'(fsm_state), 32'(ST_IDLE));
  endtask

  initial begin
    rst = 1'b1; play_en = 1'b0; key_valid = 1'b0; key_code = 4'd0;
    repeat (3) step();
    check_reset_values("reset");
    rst = 1'b0;

    // Test 1: X takes row 1-2-3
    play_en = 1'b1;
    step();
    chk("t1_state_play", 32'(fsm_state), 32'(ST_PLAY));
    chk("t1_active", 32'(game_active), 32'd1);
    press(4'd1); press(4'd4); press(4'd2); press(4'd5);
    key_pulse(4'd3);
    chk("t1_board_1clk", 32'(board), 32'(18'b01_01_01_10_10_00_00_00_00));
    chk("t1_result_pending", 32'(result), 32'd0);
    chk("t1_state_check", 32'(fsm_state), 32'(ST_CHECK));
    step();
    chk("t1_result", 32'(result), 32'd1);
    chk("t1_win_line", 32'(win_line), 32'h01);
    chk("t1_state_done", 32'(fsm_state), 32'(ST_DONE));
    chk("t1_active_done", 32'(game_active), 32'd0);
    chk("t1_cnt", 32'(move_cnt), 32'd5);
    // Cell key in DONE: ignored, no error
    key_pulse(4'd9);
    chk("t1_done_no_err", 32'(move_err), 32'd0);
    chk("t1_done_frozen", 32'(board), 32'(18'b01_01_01_10_10_00_00_00_00));

    // Test 2: restart, then occupied-cell rejection
    press(4'd0);
    chk("t2_restart_board", 32'(board), 32'd0);
    chk("t2_restart_turn", 32'(turn_o), 32'd0);
    chk("t2_restart_state", 32'(fsm_state), 32'(ST_PLAY));
    press(4'd5);
    chk("t2_turn_o", 32'(turn_o), 32'd1);
    key_pulse(4'd5);
    chk("t2_err_pulse", 32'(move_err), 32'd1);
    chk("t2_board_same", 32'(board), 32'(18'b00_00_00_00_01_00_00_00_00));
    step();
    chk("t2_err_gone", 32'(move_err), 32'd0);
    chk("t2_turn_stay", 32'(turn_o), 32'd1);
    chk("t2_cnt", 32'(move_cnt), 32'd1);
    chk("t2_state", 32'(fsm_state), 32'(ST_PLAY));

    // Test 3: draw (fresh game via a trip through IDLE)
    play_en = 1'b0;
    step();
    play_en = 1'b1;
    step();
    chk("t3_fresh_cnt", 32'(move_cnt), 32'd0);
    press(4'd1); press(4'd2); press(4'd3); press(4'd5); press(4'd4);
    press(4'd6); press(4'd8); press(4'd7);
    key_valid = 1'b0;
    press(4'd9);
    chk("t3_cnt", 32'(move_cnt), 32'd9);
    chk("t3_result_draw", 32'(result), 32'd3);
    chk("t3_win_line", 32'(win_line), 32'd0);
    chk("t3_board", 32'(board), 32'(18'b01_10_01_01_10_10_10_01_01));
    chk("t3_state_done", 32'(fsm_state), 32'(ST_DONE));
    press(4'd0);
    chk("t3_clr_board", 32'(board), 32'd0);
    chk("t3_clr_result", 32'(result), 32'd0);
    chk("t3_clr_turn", 32'(turn_o), 32'd0);
    chk("t3_clr_cnt", 32'(move_cnt), 32'd0);
    chk("t3_clr_state", 32'(fsm_state), 32'(ST_PLAY));

    // Test 4: X wins diagonal 1-5-9 on the 9th move
    press(4'd1); press(4'd2); press(4'd4); press(4'd3); press(4'd5);
    press(4'd6); press(4'd8); press(4'd7);
    chk("t4_no_early_result", 32'(result), 32'd0);
    press(4'd9);
    chk("t4_result_xwin", 32'(result), 32'd1);
    chk("t4_win_line", 32'(win_line), 32'h40);
    chk("t4_cnt", 32'(move_cnt), 32'd9);
    chk("t4_board", 32'(board), 32'(18'b01_10_10_01_01_10_10_01_01));

    // Test 6b: '*' in DONE after '#' earlier sets is_right low
    press(4'd11);
    chk("t6_hash_done", 32'(is_right), 32'd1);
    press(4'd10);
    chk("t6_star_done", 32'(is_right), 32'd0);
    chk("t6_star_frozen", 32'(result), 32'd1);

    // Test 5: play_en drop with a concurrent cell key
    press(4'd0);
    press(4'd1);
    @(negedge clk);
    play_en = 1'b0; key_valid = 1'b1; key_code = 4'd7;
    @(negedge clk);
    key_valid = 1'b0; key_code = 4'd0;
    chk("t5_state_idle", 32'(fsm_state), 32'(ST_IDLE));
    chk("t5_board_clear", 32'(board), 32'd0);
    chk("t5_active", 32'(game_active), 32'd0);
    chk("t5_no_err", 32'(move_err), 32'd0);
    chk("t5_cnt", 32'(move_cnt), 32'd0);

    // Test 6a: '#' in IDLE
    press(4'd11);
    chk("t6_hash_idle", 32'(is_right), 32'd1);
    chk("t6_idle_stays", 32'(fsm_state), 32'(ST_IDLE));
    // is_right survives entering play
    play_en = 1'b1;
    step();
    press(4'd2);
    chk("t6_right_kept", 32'(is_right), 32'd1);
    chk("t6_cell2", 32'(board), 32'(18'b00_01_00_00_00_00_00_00_00));

    // Test 6c: reset mid-game
    @(negedge clk);
    rst = 1'b1;
    step();
    check_reset_values("t6_rst");
    rst = 1'b0;
    play_en = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
